// File: rtl/rv_imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: default RAM size,
// the data word returned for out-of-range fetches, and a constant clog2 helper.
package rv_imem_responder_pkg;

    localparam int DEFAULT_MEM_DEPTH = 1024;
    localparam logic [31:0] ERR_DATA = 32'h0000_0000;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/rv_imem_responder_if.sv
// Fetch-side request/response handshake between the icache port and the
// instruction-memory responder.
interface rv_imem_responder_if #(
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int TAG_WIDTH       = 2
);
    logic                       req_valid;
    logic                       req_ready;
    logic [WORD_ADDR_WIDTH-1:0] req_addr;
    logic [TAG_WIDTH-1:0]       req_tag;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [31:0]                rsp_data;
    logic [TAG_WIDTH-1:0]       rsp_tag;
    logic                       rsp_err;

    modport master (
        output req_valid, req_addr, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err
    );

endinterface

// File: rtl/rv_rsp_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head entry is visible on rdata
// without a read strobe. Storage is not reset, only the pointers.
module rv_rsp_fifo
    import rv_imem_responder_pkg::*;
#(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int IW = clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW-1] != rptr[PW-1]) && (wptr[IW-1:0] == rptr[IW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[IW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[IW-1:0]] <= wdata;
    end

endmodule

// File: rtl/rv_imem_responder.sv
// Instruction-memory responder: synchronous RAM read on accept, fixed-latency
// pipeline into an in-order response FIFO, credit-limited by an outstanding counter.
module rv_imem_responder
    import rv_imem_responder_pkg::*;
#(
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int TAG_WIDTH       = 2,
    parameter int MEM_DEPTH       = DEFAULT_MEM_DEPTH,
    parameter int LATENCY         = 2,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    rv_imem_responder_if.slave          icache,
    input  logic                        load_valid,
    input  logic [clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                 load_data,
    output logic                        busy
);

    localparam int   AW     = clog2(MEM_DEPTH);
    localparam int   CW     = clog2(QUEUE_DEPTH + 1);
    localparam int   NS     = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int   FW     = TAG_WIDTH + 33;
    // With a single cycle of latency the RAM register itself must reach the
    // outputs, so an empty FIFO is bypassed.
    localparam logic BYPASS = (LATENCY == 1);

    logic [CW-1:0]        outstanding;
    logic                 accept;
    logic                 pop;
    logic                 in_range;
    logic [31:0]          mem [MEM_DEPTH];
    logic [NS-1:0]        vld_p;
    logic [NS-1:0]        err_p;
    logic [TAG_WIDTH-1:0] tag_p [NS];
    logic [31:0]          data_p [NS];
    logic [FW-1:0]        stage_word;
    logic [FW-1:0]        fifo_rdata;
    logic [FW-1:0]        rsp_word;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 use_stage;

    assign in_range         = (icache.req_addr >> AW) == '0;
    assign icache.req_ready = reset && (outstanding < CW'(QUEUE_DEPTH));
    assign accept           = icache.req_valid && icache.req_ready;
    assign pop              = icache.rsp_valid && icache.rsp_ready;
    assign busy             = (outstanding != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            outstanding <= '0;
            vld_p       <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            vld_p[0] <= accept;
            for (int i = 1; i < NS; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Stage p0 is the RAM output register; later stages are plain shifts.
    // Nonblocking write and read of mem give read-before-write on a shared index.
    always_ff @(posedge clk) begin
        if (load_valid) mem[load_addr] <= load_data;
        if (accept) begin
            data_p[0] <= mem[icache.req_addr[AW-1:0]];
            tag_p[0]  <= icache.req_tag;
            err_p[0]  <= !in_range;
        end
        for (int i = 1; i < NS; i++) begin
            data_p[i] <= data_p[i-1];
            tag_p[i]  <= tag_p[i-1];
            err_p[i]  <= err_p[i-1];
        end
    end

    // Pipeline exit into the response FIFO
    assign stage_word = {tag_p[NS-1], err_p[NS-1], err_p[NS-1] ? ERR_DATA : data_p[NS-1]};
    assign use_stage  = BYPASS && fifo_empty;
    assign fifo_push  = vld_p[NS-1] && !(use_stage && icache.rsp_ready);
    assign fifo_pop   = pop && !fifo_empty;

    rv_rsp_fifo #(
        .WIDTH (FW),
        .DEPTH (QUEUE_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (stage_word),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty)
    );

    assign rsp_word         = use_stage ? stage_word : fifo_rdata;
    assign icache.rsp_valid = use_stage ? vld_p[NS-1] : !fifo_empty;
    assign icache.rsp_data  = icache.rsp_valid ? rsp_word[31:0] : '0;
    assign icache.rsp_err   = icache.rsp_valid ? rsp_word[32] : 1'b0;
    assign icache.rsp_tag   = icache.rsp_valid ? rsp_word[FW-1:33] : '0;

endmodule

// File: tb/tb_rv_imem_responder.sv
// Directed bench for rv_imem_responder: a vector table for streaming reads
// plus hand-written sequences for backpressure, read-before-write and reset.
module tb_rv_imem_responder;

    typedef struct {
        logic [29:0] addr;
        logic [1:0]  tag;
        logic [31:0] data;
        logic        err;
    } vec_t;

    localparam int NV = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic        busy;
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tbl [NV];

    always #5 clk = ~clk;

    rv_imem_responder_if #(.WORD_ADDR_WIDTH(30), .TAG_WIDTH(2)) icache ();

    rv_imem_responder #(
        .WORD_ADDR_WIDTH (30),
        .TAG_WIDTH       (2),
        .MEM_DEPTH       (1024),
        .LATENCY         (2),
        .QUEUE_DEPTH     (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .icache     (icache),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_rsp(input string name, input logic [31:0] data,
                             input logic [1:0] tag, input logic err);
        check({name, "_valid"}, {31'd0, icache.rsp_valid}, 32'd1);
        check({name, "_data"},  icache.rsp_data, data);
        check({name, "_tag"},   {30'd0, icache.rsp_tag}, {30'd0, tag});
        check({name, "_err"},   {31'd0, icache.rsp_err}, {31'd0, err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset             = 1'b0;
        load_valid        = 1'b0;
        load_addr         = '0;
        load_data         = '0;
        icache.req_valid  = 1'b0;
        icache.req_addr   = '0;
        icache.req_tag    = '0;
        icache.rsp_ready  = 1'b0;

        tbl[0]  = '{30'd0,          2'd0, 32'h0000_1000, 1'b0};
        tbl[1]  = '{30'd1,          2'd1, 32'h0000_1001, 1'b0};
        tbl[2]  = '{30'd2,          2'd2, 32'h0000_1002, 1'b0};
        tbl[3]  = '{30'd3,          2'd3, 32'h0000_1003, 1'b0};
        tbl[4]  = '{30'd4,          2'd0, 32'h0000_1004, 1'b0};
        tbl[5]  = '{30'd5,          2'd1, 32'h0000_1005, 1'b0};
        tbl[6]  = '{30'd6,          2'd2, 32'h0000_1006, 1'b0};
        tbl[7]  = '{30'd7,          2'd3, 32'h0000_1007, 1'b0};
        tbl[8]  = '{30'd1024,       2'd1, 32'h0000_0000, 1'b1};
        tbl[9]  = '{30'd1023,       2'd2, 32'hCAFE_F00D, 1'b0};
        tbl[10] = '{30'h3FFF_FFFF,  2'd3, 32'h0000_0000, 1'b1};
        tbl[11] = '{30'd1027,       2'd0, 32'h0000_0000, 1'b1};

        // Load RAM while held in reset
        tick();
        for (int i = 0; i < 9; i++) begin
            load_valid = 1'b1;
            load_addr  = (i < 8) ? 10'(i) : 10'd1023;
            load_data  = (i < 8) ? 32'h1000 + 32'(i) : 32'hCAFE_F00D;
            tick();
        end
        load_valid = 1'b0;
        #1;
        check("rst_req_ready", {31'd0, icache.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, icache.rsp_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy}, 32'd0);
        check("rst_rsp_data",  icache.rsp_data, 32'd0);
        check("rst_rsp_tag",   {30'd0, icache.rsp_tag}, 32'd0);
        check("rst_rsp_err",   {31'd0, icache.rsp_err}, 32'd0);
        reset = 1'b1;
        tick();
        check("rel_req_ready", {31'd0, icache.req_ready}, 32'd1);

        // Single read, latency and busy window
        icache.rsp_ready = 1'b1;
        icache.req_valid = 1'b1;
        icache.req_addr  = 30'd3;
        icache.req_tag   = 2'd2;
        #1;
        check("t1_accept", {31'd0, icache.req_ready}, 32'd1);
        tick();
        icache.req_valid = 1'b0;
        #1;
        check("t1_busy_n1",  {31'd0, busy}, 32'd1);
        check("t1_valid_n1", {31'd0, icache.rsp_valid}, 32'd0);
        tick();
        check_rsp("t1_rsp", 32'h0000_1003, 2'd2, 1'b0);
        check("t1_busy_n2", {31'd0, busy}, 32'd1);
        tick();
        check("t1_busy_n3",  {31'd0, busy}, 32'd0);
        check("t1_valid_n3", {31'd0, icache.rsp_valid}, 32'd0);

        // Back-to-back vector stream, response two cycles after each accept
        for (int c = 0; c < NV + 2; c++) begin
            if (c < NV) begin
                icache.req_valid = 1'b1;
                icache.req_addr  = tbl[c].addr;
                icache.req_tag   = tbl[c].tag;
            end else begin
                icache.req_valid = 1'b0;
            end
            #1;
            if (c < NV) check($sformatf("vec%0d_ready", c), {31'd0, icache.req_ready}, 32'd1);
            if (c >= 2) check_rsp($sformatf("vec%0d", c - 2), tbl[c-2].data, tbl[c-2].tag, tbl[c-2].err);
            tick();
        end

        // Backpressure: only four credits, head holds steady
        icache.rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            icache.req_valid = 1'b1;
            icache.req_addr  = 30'(k);
            icache.req_tag   = 2'(k);
            #1;
            check($sformatf("bp_ready%0d", k), {31'd0, icache.req_ready}, (k < 4) ? 32'd1 : 32'd0);
            if (k >= 2) check_rsp($sformatf("bp_hold%0d", k), 32'h0000_1000, 2'd0, 1'b0);
            tick();
        end
        icache.req_valid = 1'b0;
        icache.rsp_ready = 1'b1;
        #1;
        check("bp_pop_ready", {31'd0, icache.req_ready}, 32'd0);
        check_rsp("bp_pop_head", 32'h0000_1000, 2'd0, 1'b0);
        tick();
        icache.rsp_ready = 1'b0;
        #1;
        check("bp_after_pop_ready", {31'd0, icache.req_ready}, 32'd1);
        for (int d = 0; d < 3; d++) begin
            icache.rsp_ready = 1'b1;
            #1;
            check_rsp($sformatf("bp_drain%0d", d), 32'h1001 + 32'(d), 2'(d + 1), 1'b0);
            tick();
        end
        check("bp_empty_valid", {31'd0, icache.rsp_valid}, 32'd0);
        check("bp_empty_busy",  {31'd0, busy}, 32'd0);

        // Read and load of the same index in one cycle
        icache.req_valid = 1'b1;
        icache.req_addr  = 30'd5;
        icache.req_tag   = 2'd1;
        load_valid       = 1'b1;
        load_addr        = 10'd5;
        load_data        = 32'h0000_DEAD;
        tick();
        icache.req_valid = 1'b0;
        load_valid       = 1'b0;
        tick();
        check_rsp("rbw_old", 32'h0000_1005, 2'd1, 1'b0);
        icache.req_valid = 1'b1;
        icache.req_addr  = 30'd5;
        icache.req_tag   = 2'd2;
        tick();
        icache.req_valid = 1'b0;
        tick();
        check_rsp("rbw_new", 32'h0000_DEAD, 2'd2, 1'b0);
        tick();

        // Reset with three requests in flight
        icache.rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            icache.req_valid = 1'b1;
            icache.req_addr  = 30'(c);
            icache.req_tag   = 2'(c);
            tick();
        end
        icache.req_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_ready_low", {31'd0, icache.req_ready}, 32'd0);
        tick();
        check("mid_rst_valid", {31'd0, icache.rsp_valid}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        check("mid_rst_data",  icache.rsp_data, 32'd0);
        reset = 1'b1;
        tick();
        check("mid_rel_ready", {31'd0, icache.req_ready}, 32'd1);
        check("mid_rel_valid", {31'd0, icache.rsp_valid}, 32'd0);
        icache.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("mid_stale%0d", c), {31'd0, icache.rsp_valid}, 32'd0);
        end
        check("mid_final_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_imem_responder.md
# rv_imem_responder

Instruction-memory responder for the fetch engine's icache request/response handshake. Accepts word-address read requests with a tag, reads an on-chip instruction RAM through a fixed-latency pipeline, and returns data with the original tag in request order through a credit-limited response queue. It sits where the icache or memory model normally serves the fetch unit, and is used for bring-up and as the backing store behind the core.

## Interface
- `WORD_ADDR_WIDTH`, 30: request word-address width.
- `TAG_WIDTH`, 2: request/response tag width.
- `MEM_DEPTH`, 1024: RAM words, power of two.
- `LATENCY`, 2: accept-to-response cycles, 1..4.
- `QUEUE_DEPTH`, 4: max outstanding requests, power of two, ≥ `LATENCY`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset.
- `icache_req_if_valid` in 1: request valid.
- `icache_req_if_addr` in `WORD_ADDR_WIDTH`: word address.
- `icache_req_if_tag` in `TAG_WIDTH`: request tag.
- `icache_req_if_ready` out 1: request accepted when valid & ready.
- `icache_rsp_if_valid` out 1: response valid.
- `icache_rsp_if_data` out 32: instruction word.
- `icache_rsp_if_tag` out `TAG_WIDTH`: echoed tag.
- `icache_rsp_if_err` out 1: address was out of range.
- `icache_rsp_if_ready` in 1: response consumed when valid & ready.
- `load_valid` in 1: RAM write strobe.
- `load_addr` in clog2(`MEM_DEPTH`): RAM write index.
- `load_data` in 32: RAM write data.
- `busy` out 1: outstanding ≠ 0.

## Operation
- `outstanding` counter, width clog2(`QUEUE_DEPTH`+1), counts accepted requests not yet popped. It increments on accept and decrements on pop. Both in one cycle leaves it unchanged.
- `icache_req_if_ready` = (`outstanding` < `QUEUE_DEPTH`) && reset deasserted. It is a function of the registered counter only. A pop does not free a slot until the next cycle.
- Out of range means `addr` ≥ `MEM_DEPTH`. The RAM index is `addr[clog2(MEM_DEPTH)-1:0]`. An out-of-range response returns data 0x00000000 with `err`=1. Otherwise `err`=0.
- RAM read is synchronous and issued on accept. Valid, tag and err travel through `LATENCY`-1 shift stages alongside the data, then write into a `QUEUE_DEPTH`-entry FIFO. The credit limit guarantees the FIFO never overflows.
- FIFO head drives the response outputs directly. Pop on `icache_rsp_if_valid` & `icache_rsp_if_ready`. Responses are returned strictly in acceptance order.
- `load_valid` writes the RAM every cycle it is high, independent of request traffic. On a same-cycle read and load to the same index, the read returns the old data (read-before-write).

## Timing
- Reset (`reset`=0 at a clock edge): clears `outstanding`, pipeline valids and FIFO pointers. Output reset values: `icache_req_if_ready`=0 during reset, `icache_rsp_if_valid`=0, data/tag/err=0, `busy`=0.
- RAM contents are not reset. Reset mid-operation silently drops all in-flight and queued responses.
- Latency: a request accepted in cycle N appears as a response in cycle N+`LATENCY`, provided the FIFO is empty at its arrival.
- Throughput: with `icache_rsp_if_ready` held high, one request accepted and one response delivered per cycle, without bubbles.
- Backpressure: while `icache_rsp_if_ready`=0, responses hold stable (valid, data, tag, err unchanged). Acceptance stops once `outstanding` = `QUEUE_DEPTH`.
- FIFO pointers are clog2(`QUEUE_DEPTH`)+1 bits and wrap naturally. Full = MSB differs and the rest are equal. Empty = pointers equal.

## Structure
- The shared package (`RV_define.vh` addition) holds the default `MEM_DEPTH`, the error-data constant 0x00000000, and the clog2 helper.
- One sub-module, `rv_rsp_fifo`: a parameterised synchronous FIFO with width `TAG_WIDTH`+33 and depth `QUEUE_DEPTH`, reusable elsewhere in the core.
- RAM is inferred inside the top level, with no vendor primitives.

## Test plan
- Load words 0..7 with 0x1000+i; send addr 3, tag 2, with `rsp_ready` high. Required: response in cycle N+2 with data 0x1003, tag 2, err 0. `busy` is high for 2 cycles.
- Send 8 back-to-back requests, addrs 0..7, tags cycling 0..3, with `rsp_ready` high. Required: 8 consecutive responses, in order, one per cycle; `req_ready` never drops.
- Hold `rsp_ready` low and issue requests. Required: exactly 4 accepted, `req_ready` falls after the 4th, and the head response stays stable. Then raise `rsp_ready` for 1 cycle. Required: one pop, and `req_ready` rises the following cycle.
- Request addr 1024. Required: data 0x00000000, err 1, tag echoed.
- Same cycle: read addr 5 and load addr 5 with 0xDEAD. Required: the response returns the old value. A subsequent read returns 0xDEAD.
- Assert reset with 3 requests outstanding. Required: `rsp_valid`=0 and `busy`=0 after the reset edge, no stale responses after release, and `req_ready`=1 in the first cycle after release.
